// File: rtl/logic_rop_pkg.sv
// Shared definitions for the logical raster-op pipe: opcode encodings,
// the reset opcode and the drain FSM state type.
package logic_rop_pkg;

  // GL-style logic op encodings (s = source, d = destination).
  localparam logic [3:0] ROP_CLEAR     = 4'h0;  // 0
  localparam logic [3:0] ROP_AND       = 4'h1;  // s & d
  localparam logic [3:0] ROP_AND_REV   = 4'h2;  // s & ~d
  localparam logic [3:0] ROP_COPY      = 4'h3;  // s
  localparam logic [3:0] ROP_AND_INV   = 4'h4;  // ~s & d
  localparam logic [3:0] ROP_NOOP      = 4'h5;  // d
  localparam logic [3:0] ROP_XOR       = 4'h6;  // s ^ d
  localparam logic [3:0] ROP_OR        = 4'h7;  // s | d
  localparam logic [3:0] ROP_NOR       = 4'h8;  // ~(s | d)
  localparam logic [3:0] ROP_EQUIV     = 4'h9;  // ~(s ^ d)
  localparam logic [3:0] ROP_INVERT    = 4'hA;  // ~d
  localparam logic [3:0] ROP_OR_REV    = 4'hB;  // s | ~d
  localparam logic [3:0] ROP_COPY_INV  = 4'hC;  // ~s
  localparam logic [3:0] ROP_OR_INV    = 4'hD;  // ~s | d
  localparam logic [3:0] ROP_NAND      = 4'hE;  // ~(s & d)
  localparam logic [3:0] ROP_SET       = 4'hF;  // all ones

  // Opcode loaded on reset.
  localparam logic [3:0] ROP_RESET_OP  = ROP_COPY;

  // RUN accepts pixels; DRAIN blocks input until the pipe is empty so an
  // opcode change never affects a pixel already in flight.
  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_e;

endpackage

// File: rtl/logic_rop_alu.sv
// Combinational bitwise logic-op evaluator over a W-bit word.
module logic_rop_alu
  import logic_rop_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] s,
  input  logic [W-1:0] d,
  input  logic [3:0]   opcode,
  output logic [W-1:0] f
);

  // Select the logic function for the active opcode.
  always_comb begin
    // NOTE: assigning a default before the case keeps this purely combinational; any path leaving f unassigned would infer a latch.
    f = '0;
    case (opcode)
      ROP_CLEAR:    f = '0;
      ROP_AND:      f = s & d;
      ROP_AND_REV:  f = s & ~d;
      ROP_COPY:     f = s;
      ROP_AND_INV:  f = ~s & d;
      ROP_NOOP:     f = d;
      ROP_XOR:      f = s ^ d;
      ROP_OR:       f = s | d;
      ROP_NOR:      f = ~(s | d);
      ROP_EQUIV:    f = ~(s ^ d);
      ROP_INVERT:   f = ~d;
      ROP_OR_REV:   f = s | ~d;
      ROP_COPY_INV: f = ~s;
      ROP_OR_INV:   f = ~s | d;
      ROP_NAND:     f = ~(s & d);
      ROP_SET:      f = '1;
      default:      f = '0;
    endcase
  end

endmodule

// File: rtl/logic_rop_pipe.sv
// Two-stage logical raster-op pipe with valid/ready flow control, per-channel
// write mask, drain-before-update opcode config and a written-pixel counter.
module logic_rop_pipe
  import logic_rop_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8,
  parameter int TAG_W  = 16,
  parameter int CNT_W  = 32,
  localparam int W     = NUM_CH * CH_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W-1:0]      in_src,
  input  logic [W-1:0]      in_dest,
  input  logic [NUM_CH-1:0] in_mask,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      out_data,
  output logic [TAG_W-1:0]  out_tag,
  input  logic              cfg_valid,
  input  logic [3:0]        cfg_opcode,
  output logic              cfg_ready,
  output logic [CNT_W-1:0]  pix_count,
  output logic [3:0]        cur_opcode
);

  // Stage 1: raw operands.
  logic              s1_valid_q, s1_valid_d;
  logic [W-1:0]      s1_src_q,   s1_src_d;
  logic [W-1:0]      s1_dest_q,  s1_dest_d;
  logic [NUM_CH-1:0] s1_mask_q,  s1_mask_d;
  logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
  // Stage 2: masked result (output register).
  logic              s2_valid_q, s2_valid_d;
  logic [W-1:0]      s2_data_q,  s2_data_d;
  logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
  logic              s2_any_q,   s2_any_d;   // pixel writes at least one channel
  // Control.
  state_e            state_q,    state_d;
  logic [3:0]        opcode_q,   opcode_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  logic              s1_load;
  logic              s2_load;
  logic [W-1:0]      alu_f;

  logic_rop_alu #(.W(W)) u_alu (
    .s      (s1_src_q),
    .d      (s1_dest_q),
    .opcode (opcode_q),
    .f      (alu_f)
  );

  // Handshake decode: S2 loads when empty or draining; input accepted only in RUN without a pending config.
  always_comb begin
    s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
    in_ready = (state_q == RUN) & ~cfg_valid & (~s1_valid_q | s2_load);
    s1_load  = in_valid & in_ready;
  end

  // Next-state for both pipeline stages, masking applied on the S1->S2 transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_src_d   = s1_src_q;
    s1_dest_d  = s1_dest_q;
    s1_mask_d  = s1_mask_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_tag_d   = s2_tag_q;
    s2_any_d   = s2_any_q;

    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_src_d   = in_src;
      s1_dest_d  = in_dest;
      s1_mask_d  = in_mask;
      s1_tag_d   = in_tag;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end

    if (s2_load) begin
      s2_valid_d = 1'b1;
      s2_tag_d   = s1_tag_q;
      s2_any_d   = |s1_mask_q;
      for (int i = 0; i < NUM_CH; i++) begin
        s2_data_d[i*CH_W +: CH_W] = s1_mask_q[i] ? alu_f[i*CH_W +: CH_W]
                                                 : s1_dest_q[i*CH_W +: CH_W];
      end
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Config FSM: drain the pipe, then apply the new opcode with a one-cycle ack.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cfg_ready = 1'b0;
    case (state_q)
      RUN: begin
        if (cfg_valid) state_d = DRAIN;
      end
      DRAIN: begin
        if (!cfg_valid) begin
          state_d = RUN;
        end else if (!s1_valid_q && !s2_valid_q) begin
          cfg_ready = 1'b1;
          opcode_d  = cfg_opcode;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Saturating count of delivered pixels that wrote at least one channel.
  always_comb begin
    count_d = count_q;
    if (out_valid && out_ready && s2_any_q && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // State registers; reset discards in-flight pixels and restores COPY.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, so stage order in this block does not matter.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_src_q   <= '0;
      s1_dest_q  <= '0;
      s1_mask_q  <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_any_q   <= 1'b0;
      state_q    <= RUN;
      opcode_q   <= ROP_RESET_OP;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_src_q   <= s1_src_d;
      s1_dest_q  <= s1_dest_d;
      s1_mask_q  <= s1_mask_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_tag_q   <= s2_tag_d;
      s2_any_q   <= s2_any_d;
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      count_q    <= count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_data   = s2_data_q;
  assign out_tag    = s2_tag_q;
  assign pix_count  = count_q;
  assign cur_opcode = opcode_q;

endmodule

// File: tb/tb_logic_rop_pipe.sv
// Directed self-checking bench for logic_rop_pipe.
module tb_logic_rop_pipe;
  import logic_rop_pkg::*;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 8;
  localparam int TAG_W  = 16;
  localparam int CNT_W  = 32;
  localparam int W      = NUM_CH * CH_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_src;
  logic [W-1:0]      in_dest;
  logic [NUM_CH-1:0] in_mask;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              cfg_valid;
  logic [3:0]        cfg_opcode;
  logic              cfg_ready;
  logic [CNT_W-1:0]  pix_count;
  logic [3:0]        cur_opcode;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [W-1:0] SRC  = 32'hF0F0_AA55;
  localparam logic [W-1:0] DEST = 32'h0FF0_5A5A;

  logic_rop_pipe #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .TAG_W  (TAG_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src     (in_src),
    .in_dest    (in_dest),
    .in_mask    (in_mask),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .cfg_valid  (cfg_valid),
    .cfg_opcode (cfg_opcode),
    .cfg_ready  (cfg_ready),
    .pix_count  (pix_count),
    .cur_opcode (cur_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one pixel and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] src, input logic [W-1:0] dest,
                      input logic [NUM_CH-1:0] mask, input logic [TAG_W-1:0] tag);
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_src   = src;
    in_dest  = dest;
    in_mask  = mask;
    in_tag   = tag;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("send_accept", 64'(ok), 64'd1);
  endtask

  // Issue an opcode change and wait for its acknowledge.
  task automatic do_cfg(input logic [3:0] op);
    bit ok;
    ok         = 1'b0;
    cfg_valid  = 1'b1;
    cfg_opcode = op;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (cfg_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok) begin
      @(posedge clk); #1;
    end
    cfg_valid = 1'b0;
    check("cfg_ack", 64'(ok), 64'd1);
    check("cfg_opcode", 64'(cur_opcode), 64'(op));
  endtask

  // Single pixel with out_ready high: checks two-cycle latency and the result.
  task automatic one_pixel(input string name, input logic [W-1:0] src, input logic [W-1:0] dest,
                           input logic [NUM_CH-1:0] mask, input logic [TAG_W-1:0] tag,
                           input logic [W-1:0] exp);
    out_ready = 1'b1;
    send(src, dest, mask, tag);
    check({name, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({name, "_valid"}, 64'(out_valid), 64'd1);
    check({name, "_data"}, 64'(out_data), 64'(exp));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  logic [W-1:0]     st_src  [8];
  logic [W-1:0]     st_dest [8];
  logic [TAG_W-1:0] st_tag  [8];
  logic [W-1:0]     od [3];
  logic [TAG_W-1:0] ot [3];
  int               nrx;
  int               nout;
  int               pulses;
  int               outs_at_cfg;
  bit               held;
  logic [63:0]      held_val;
  bit               seen;
  bit               go, gc, gi;

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_src     = '0;
    in_dest    = '0;
    in_mask    = '0;
    in_tag     = '0;
    out_ready  = 1'b0;
    cfg_valid  = 1'b0;
    cfg_opcode = '0;

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    check("rst_pix_count", 64'(pix_count), 64'd0);
    check("rst_opcode", 64'(cur_opcode), 64'h3);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("run_in_ready", 64'(in_ready), 64'd1);

    // Default COPY, then XOR / XNOR / NAND on the same pixel.
    one_pixel("copy", SRC, DEST, 4'hF, 16'h0001, 32'hF0F0_AA55);
    check("copy_count", 64'(pix_count), 64'd1);
    do_cfg(4'h6);
    one_pixel("xor", SRC, DEST, 4'hF, 16'h0002, 32'hFF00_F00F);
    do_cfg(4'h9);
    one_pixel("xnor", SRC, DEST, 4'hF, 16'h0003, 32'h00FF_0FF0);
    do_cfg(4'hE);
    one_pixel("nand", SRC, DEST, 4'hF, 16'h0004, 32'hFF0F_F5AF);
    check("nand_count", 64'(pix_count), 64'd4);

    // Partial and empty masks under XOR.
    do_cfg(4'h6);
    one_pixel("mask5", SRC, DEST, 4'b0101, 16'h0005, 32'h0F00_5A0F);
    check("mask5_count", 64'(pix_count), 64'd5);
    one_pixel("mask0", SRC, DEST, 4'h0, 16'h0006, DEST);
    check("mask0_count", 64'(pix_count), 64'd5);

    // Stream 8 pixels while out_ready follows 1,0,0,1.
    for (int i = 0; i < 8; i++) begin
      st_src[i]  = 32'h0101_0101 * (i + 1);
      st_dest[i] = 32'hA5A5_0000 | 32'(i * 3);
      st_tag[i]  = 16'h0100 + 16'(i);
    end
    nrx  = 0;
    held = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(st_src[i], st_dest[i], 4'hF, st_tag[i]);
      end
      begin
        for (int c = 0; c < 300 && nrx < 8; c++) begin
          @(posedge clk); #1;
          out_ready = (c % 4 == 0) || (c % 4 == 3);
          #1;
          if (held) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_hold", {16'h0, out_tag, out_data}, held_val);
          end
          held = 1'b0;
          if (out_valid) begin
            if (out_ready) begin
              check("stream_data", 64'(out_data), 64'(st_src[nrx] ^ st_dest[nrx]));
              check("stream_tag", 64'(out_tag), 64'(st_tag[nrx]));
              nrx++;
            end else begin
              held     = 1'b1;
              held_val = {16'h0, out_tag, out_data};
            end
          end
        end
      end
    join
    check("stream_count_rx", 64'(nrx), 64'd8);
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stream_no_dup", 64'(out_valid), 64'd0);
    check("stream_pix_count", 64'(pix_count), 64'd13);

    // Config arriving with a pixel: two pixels in flight drain with XOR, then CLEAR applies.
    out_ready = 1'b0;
    send(SRC, DEST, 4'hF, 16'h0200);
    send(32'h1234_5678, 32'hFFFF_0000, 4'hF, 16'h0201);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    in_src     = 32'hDEAD_BEEF;
    in_dest    = 32'h1357_9BDF;
    in_mask    = 4'hF;
    in_tag     = 16'h0202;
    cfg_valid  = 1'b1;
    cfg_opcode = 4'h0;
    #1;
    check("cfg_blocks_in", 64'(in_ready), 64'd0);
    nout        = 0;
    pulses      = 0;
    outs_at_cfg = -1;
    for (int c = 0; c < 40 && nout < 3; c++) begin
      #1;
      go = out_valid;
      gc = cfg_ready;
      gi = in_valid & in_ready;
      if (go) begin
        od[nout] = out_data;
        ot[nout] = out_tag;
        nout++;
      end
      if (gc) begin
        pulses++;
        outs_at_cfg = nout;
      end
      @(posedge clk); #1;
      if (gc) cfg_valid = 1'b0;
      if (gi) in_valid = 1'b0;
    end
    check("drain_nout", 64'(nout), 64'd3);
    check("drain_a_data", 64'(od[0]), 64'hFF00_F00F);
    check("drain_a_tag", 64'(ot[0]), 64'h0200);
    check("drain_b_data", 64'(od[1]), 64'hEDCB_5678);
    check("drain_b_tag", 64'(ot[1]), 64'h0201);
    check("drain_c_data", 64'(od[2]), 64'h0);
    check("drain_c_tag", 64'(ot[2]), 64'h0202);
    check("drain_pulses", 64'(pulses), 64'd1);
    check("drain_ack_after", 64'(outs_at_cfg), 64'd2);
    check("drain_opcode", 64'(cur_opcode), 64'h0);
    check("drain_pix_count", 64'(pix_count), 64'd16);

    // Asynchronous reset with pixels in flight.
    out_ready = 1'b0;
    send(SRC, DEST, 4'hF, 16'h0300);
    send(SRC, DEST, 4'hF, 16'h0301);
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_pix_count", 64'(pix_count), 64'd0);
    check("arst_opcode", 64'(cur_opcode), 64'h3);
    check("arst_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | out_valid;
    end
    check("arst_no_stale", 64'(seen), 64'd0);
    check("arst_count_hold", 64'(pix_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
